lpm_tbl_arbiter: RTL

Arbiter and sequencer for the single read/write port of the router's LPM table inside the output-port-lookup pcore. It shares the port between two requesters: requester 0 is the host register path and requester 1 is the route-update engine. Requests are granted round-robin, and each granted access is driven through the table's one-cycle req/ack protocol. Accesses that never acknowledge are terminated by a timeout and counted.

---
 rtl/lpm_tbl_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/lpm_tbl_arbiter.sv
// Round-robin arbiter that shares the LPM table's single read/write port between the
// host register path (r0) and the route-update engine (r1), with ack timeout and abort counting.
module lpm_tbl_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5,
    parameter int TBL_DATA_WIDTH     = 128,
    parameter int ACK_TIMEOUT        = 15
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_RESETN,
    input  logic                          r0_req,
    input  logic                          r0_wr,
    input  logic [TBL_ADDR_WIDTH-1:0]     r0_addr,
    input  logic [TBL_DATA_WIDTH-1:0]     r0_wdata,
    input  logic                          r1_req,
    input  logic                          r1_wr,
    input  logic [TBL_ADDR_WIDTH-1:0]     r1_addr,
    input  logic [TBL_DATA_WIDTH-1:0]     r1_wdata,
    output logic                          r0_done,
    output logic                          r1_done,
    output logic                          r0_err,
    output logic                          r1_err,
    output logic [TBL_DATA_WIDTH-1:0]     r_rdata,
    output logic                          tbl_rd_req,
    output logic                          tbl_wr_req,
    output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
    output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
    output logic [TBL_DATA_WIDTH-1:0]     tbl_wr_data,
    input  logic [TBL_DATA_WIDTH-1:0]     tbl_rd_data,
    input  logic                          tbl_rd_ack,
    input  logic                          tbl_wr_ack,
    output logic [C_S_AXI_DATA_WIDTH-1:0] timeout_count,
    input  logic                          count_clear
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]              TMO_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]              CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]              CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] TC_ZERO   = {C_S_AXI_DATA_WIDTH{1'b0}};
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] TC_ONE    = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] TC_MAX    = {C_S_AXI_DATA_WIDTH{1'b1}};
    localparam logic [TBL_ADDR_WIDTH-1:0]     ADDR_ZERO = {TBL_ADDR_WIDTH{1'b0}};
    localparam logic [TBL_DATA_WIDTH-1:0]     DATA_ZERO = {TBL_DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                          state_r, state_s;
    logic                            last_grant_r, last_grant_s;
    logic                            gnt_id_r, gnt_id_s;
    logic                            gnt_wr_r, gnt_wr_s;
    logic [TBL_ADDR_WIDTH-1:0]       gnt_addr_r, gnt_addr_s;
    logic [TBL_DATA_WIDTH-1:0]       gnt_wdata_r, gnt_wdata_s;
    logic [CNT_W-1:0]                wait_cnt_r, wait_cnt_s;
    logic                            r0_done_r, r0_done_s, r1_done_r, r1_done_s;
    logic                            r0_err_r, r0_err_s, r1_err_r, r1_err_s;
    logic [TBL_DATA_WIDTH-1:0]       rdata_r, rdata_s;
    logic                            tbl_rd_req_r, tbl_rd_req_s, tbl_wr_req_r, tbl_wr_req_s;
    logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr_r, tbl_rd_addr_s, tbl_wr_addr_r, tbl_wr_addr_s;
    logic [TBL_DATA_WIDTH-1:0]       tbl_wr_data_r, tbl_wr_data_s;
    logic [C_S_AXI_DATA_WIDTH-1:0]   tmo_cnt_r, tmo_cnt_s;
    logic                            tmo_inc_s;
    logic                            ack_ok_s;
    logic                            pick_s;
    logic                            sel_wr_s;
    logic [TBL_ADDR_WIDTH-1:0]       sel_addr_s;
    logic [TBL_DATA_WIDTH-1:0]       sel_wdata_s;

    // Round-robin choice among the live requests; on a tie the one not granted last wins.
    always_comb begin
        pick_s = 1'b0;
        if (r0_req && r1_req) begin
            pick_s = ~last_grant_r;
        end else if (r1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        sel_wr_s    = pick_s ? r1_wr    : r0_wr;
        sel_addr_s  = pick_s ? r1_addr  : r0_addr;
        sel_wdata_s = pick_s ? r1_wdata : r0_wdata;
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s       = state_r;
        last_grant_s  = last_grant_r;
        gnt_id_s      = gnt_id_r;
        gnt_wr_s      = gnt_wr_r;
        gnt_addr_s    = gnt_addr_r;
        gnt_wdata_s   = gnt_wdata_r;
        wait_cnt_s    = wait_cnt_r;
        r0_done_s     = 1'b0;
        r1_done_s     = 1'b0;
        r0_err_s      = 1'b0;
        r1_err_s      = 1'b0;
        rdata_s       = rdata_r;
        tbl_rd_req_s  = 1'b0;
        tbl_wr_req_s  = 1'b0;
        tbl_rd_addr_s = tbl_rd_addr_r;
        tbl_wr_addr_s = tbl_wr_addr_r;
        tbl_wr_data_s = tbl_wr_data_r;
        tmo_inc_s     = 1'b0;
        tmo_cnt_s     = tmo_cnt_r;
        ack_ok_s      = gnt_wr_r ? tbl_wr_ack : tbl_rd_ack;

        case (state_r)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    last_grant_s = pick_s;
                    gnt_id_s     = pick_s;
                    gnt_wr_s     = sel_wr_s;
                    gnt_addr_s   = sel_addr_s;
                    gnt_wdata_s  = sel_wdata_s;
                    if (sel_wr_s) begin
                        tbl_wr_req_s  = 1'b1;
                        tbl_wr_addr_s = sel_addr_s;
                        tbl_wr_data_s = sel_wdata_s;
                    end else begin
                        tbl_rd_req_s  = 1'b1;
                        tbl_rd_addr_s = sel_addr_s;
                    end
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_s = CNT_ZERO;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // A matching ack on the final counted cycle still wins over the timeout.
                if (ack_ok_s) begin
                    if (!gnt_wr_r) begin
                        rdata_s = tbl_rd_data;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    r0_done_s = ~gnt_id_r;
                    r1_done_s = gnt_id_r;
                    state_s   = ST_DONE;
                end else if (wait_cnt_r == TMO_LIMIT) begin
                    rdata_s   = DATA_ZERO;
                    r0_done_s = ~gnt_id_r;
                    r1_done_s = gnt_id_r;
                    r0_err_s  = ~gnt_id_r;
                    r1_err_s  = gnt_id_r;
                    tmo_inc_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (count_clear) begin
            tmo_cnt_s = TC_ZERO;
        end else if (tmo_inc_s && (tmo_cnt_r != TC_MAX)) begin
            tmo_cnt_s = tmo_cnt_r + TC_ONE;
        end else begin
            tmo_cnt_s = tmo_cnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant context, wait counter and all registered outputs.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            last_grant_r  <= 1'b1;
            gnt_id_r      <= 1'b0;
            gnt_wr_r      <= 1'b0;
            gnt_addr_r    <= ADDR_ZERO;
            gnt_wdata_r   <= DATA_ZERO;
            wait_cnt_r    <= CNT_ZERO;
            r0_done_r     <= 1'b0;
            r1_done_r     <= 1'b0;
            r0_err_r      <= 1'b0;
            r1_err_r      <= 1'b0;
            rdata_r       <= DATA_ZERO;
            tbl_rd_req_r  <= 1'b0;
            tbl_wr_req_r  <= 1'b0;
            tbl_rd_addr_r <= ADDR_ZERO;
            tbl_wr_addr_r <= ADDR_ZERO;
            tbl_wr_data_r <= DATA_ZERO;
            tmo_cnt_r     <= TC_ZERO;
        end else begin
            last_grant_r  <= last_grant_s;
            gnt_id_r      <= gnt_id_s;
            gnt_wr_r      <= gnt_wr_s;
            gnt_addr_r    <= gnt_addr_s;
            gnt_wdata_r   <= gnt_wdata_s;
            wait_cnt_r    <= wait_cnt_s;
            r0_done_r     <= r0_done_s;
            r1_done_r     <= r1_done_s;
            r0_err_r      <= r0_err_s;
            r1_err_r      <= r1_err_s;
            rdata_r       <= rdata_s;
            tbl_rd_req_r  <= tbl_rd_req_s;
            tbl_wr_req_r  <= tbl_wr_req_s;
            tbl_rd_addr_r <= tbl_rd_addr_s;
            tbl_wr_addr_r <= tbl_wr_addr_s;
            tbl_wr_data_r <= tbl_wr_data_s;
            tmo_cnt_r     <= tmo_cnt_s;
        end
    end

    assign r0_done       = r0_done_r;
    assign r1_done       = r1_done_r;
    assign r0_err        = r0_err_r;
    assign r1_err        = r1_err_r;
    assign r_rdata       = rdata_r;
    assign tbl_rd_req    = tbl_rd_req_r;
    assign tbl_wr_req    = tbl_wr_req_r;
    assign tbl_rd_addr   = tbl_rd_addr_r;
    assign tbl_wr_addr   = tbl_wr_addr_r;
    assign tbl_wr_data   = tbl_wr_data_r;
    assign timeout_count = tmo_cnt_r;

endmodule
